// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Two-requester I2C register transaction sequencer. Arbitrates
//               between two requesters, then drives a byte-level I2C engine
//               through a register write or random-read sequence, with
//               per-command response timeout and NACK handling.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit RR_EN          = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_rw_i,
  input  logic [13:0] req_dev_i,
  input  logic [15:0] req_reg_i,
  input  logic [15:0] req_wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [7:0]  rdata_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [1:0]  cmd_op_o,
  output logic [7:0]  cmd_data_o,
  output logic        cmd_nack_o,
  input  logic        rsp_valid_i,
  input  logic        rsp_ack_i,
  input  logic [7:0]  rsp_data_i
);

  localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TMO      = c_TW'(TIMEOUT_CYCLES);
  localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
  localparam logic [1:0]      c_OP_START = 2'd0;
  localparam logic [1:0]      c_OP_WRITE = 2'd1;
  localparam logic [1:0]      c_OP_READ  = 2'd2;
  localparam logic [1:0]      c_OP_STOP  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DEVW   = 4'd2,
    S_REG    = 4'd3,
    S_WDATA  = 4'd4,
    S_RSTART = 4'd5,
    S_DEVR   = 4'd6,
    S_RDATA  = 4'd7,
    S_STOP   = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      r_gnt;
  logic            r_sel;      // index of the granted requester
  logic            r_prio;     // requester favoured on a tie
  logic            r_rw;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg;
  logic [7:0]      r_wdata;
  logic            r_err;
  logic            r_issued;   // command handshaken, response outstanding
  logic [c_TW-1:0] r_tmo;
  logic [7:0]      r_rdata;

  logic            w_pick;
  logic            w_in_cmd;
  logic            w_rsp;
  logic [c_TW-1:0] w_tmo_inc;
  logic            w_tmo_hit;
  logic            w_wr_nack;
  logic            w_hs;

  // A lone requester always wins; a tie goes to the favoured one (or 0).
  assign w_pick = (req_i == 2'b11) ? (RR_EN ? r_prio : 1'b0) : req_i[1];

  // Responses only count while a command is outstanding; a response in the
  // terminal-count cycle wins over the timeout.
  assign w_rsp     = r_issued & rsp_valid_i;
  assign w_tmo_inc = r_tmo + c_TMO_ONE;
  assign w_tmo_hit = r_issued & ~rsp_valid_i & (w_tmo_inc == c_TMO);
  assign w_wr_nack = w_rsp & (cmd_op_o == c_OP_WRITE) & ~rsp_ack_i;
  assign w_hs      = cmd_valid_o & cmd_ready_i;

  assign gnt_o   = r_gnt;
  assign done_o  = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign err_o   = ((r_state == S_DONE) && r_err) ? r_gnt : 2'b00;
  assign rdata_o = r_rdata;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state sequencing and per-state byte-engine command.
  always_comb begin
    w_next     = r_state;
    w_in_cmd   = 1'b1;
    cmd_op_o   = c_OP_START;
    cmd_data_o = 8'h00;
    cmd_nack_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_cmd = 1'b0;
        if (|req_i) w_next = S_START;
      end
      S_START: begin
        if (w_rsp) w_next = S_DEVW;
      end
      S_DEVW: begin
        cmd_op_o   = c_OP_WRITE;
        cmd_data_o = {r_dev, 1'b0};
        if (w_rsp) w_next = rsp_ack_i ? S_REG : S_STOP;
      end
      S_REG: begin
        cmd_op_o   = c_OP_WRITE;
        cmd_data_o = r_reg;
        if (w_rsp) w_next = !rsp_ack_i ? S_STOP : (r_rw ? S_RSTART : S_WDATA);
      end
      S_WDATA: begin
        cmd_op_o   = c_OP_WRITE;
        cmd_data_o = r_wdata;
        if (w_rsp) w_next = S_STOP;
      end
      S_RSTART: begin
        if (w_rsp) w_next = S_DEVR;
      end
      S_DEVR: begin
        cmd_op_o   = c_OP_WRITE;
        cmd_data_o = {r_dev, 1'b1};
        if (w_rsp) w_next = rsp_ack_i ? S_RDATA : S_STOP;
      end
      S_RDATA: begin
        cmd_op_o   = c_OP_READ;
        cmd_nack_o = 1'b1;
        if (w_rsp) w_next = S_STOP;
      end
      S_STOP: begin
        cmd_op_o = c_OP_STOP;
        if (w_rsp) w_next = S_DONE;
      end
      S_DONE: begin
        w_in_cmd = 1'b0;
        w_next   = S_IDLE;
      end
      default: begin
        w_in_cmd = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
    // A stalled STOP cannot be retried with another STOP, so finish instead.
    if (w_tmo_hit) w_next = (r_state == S_STOP) ? S_DONE : S_STOP;
    cmd_valid_o = w_in_cmd & ~r_issued;
  end

  // Outstanding-command flag and response timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issued <= 1'b0;
      r_tmo    <= '0;
    end else if (w_hs) begin
      r_issued <= 1'b1;
      r_tmo    <= '0;
    end else if (w_next != r_state) begin
      r_issued <= 1'b0;
      r_tmo    <= '0;
    end else if (r_issued) begin
      r_tmo    <= w_tmo_inc;
    end
  end

  // Grant, latched request fields, sticky error and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt   <= 2'b00;
      r_sel   <= 1'b0;
      r_prio  <= 1'b0;
      r_rw    <= 1'b0;
      r_dev   <= 7'h00;
      r_reg   <= 8'h00;
      r_wdata <= 8'h00;
      r_err   <= 1'b0;
    end else if ((r_state == S_IDLE) && (|req_i)) begin
      r_gnt   <= w_pick ? 2'b10 : 2'b01;
      r_sel   <= w_pick;
      r_rw    <= req_rw_i[w_pick];
      r_dev   <= w_pick ? req_dev_i[13:7]    : req_dev_i[6:0];
      r_reg   <= w_pick ? req_reg_i[15:8]    : req_reg_i[7:0];
      r_wdata <= w_pick ? req_wdata_i[15:8]  : req_wdata_i[7:0];
    end else if (r_state == S_DONE) begin
      r_gnt   <= 2'b00;
      r_err   <= 1'b0;
      r_prio  <= ~r_sel;
    end else if (w_tmo_hit || w_wr_nack) begin
      r_err   <= 1'b1;
    end
  end

  // Read byte capture; held until the next read completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          r_rdata <= 8'h00;
    else if ((r_state == S_RDATA) && w_rsp) r_rdata <= rsp_data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed self-checking bench for i2c_txn_arbiter. A scripted
//               byte-engine responder logs every accepted command; a second
//               fixed-priority instance runs in lockstep for arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_rw;
  logic [13:0] req_dev;
  logic [15:0] req_reg, req_wdata;
  logic        cmd_ready, rsp_valid, rsp_ack;
  logic [7:0]  rsp_data;

  logic [1:0] gnt, done, err, cmd_op;
  logic [7:0] rdata, cmd_data;
  logic       cmd_valid, cmd_nack;
  logic [1:0] gnt_b, done_b, err_b, cmd_op_b;
  logic [7:0] rdata_b, cmd_data_b;
  logic       cmd_valid_b, cmd_nack_b;

  int total = 0;
  int bad   = 0;

  // Responder state: log of accepted commands and scripted behaviour.
  int         eng_cnt = 0;
  int         eng_hold = -1;
  int         eng_nack = -1;
  logic [7:0] eng_rdata = 8'h00;
  logic [1:0] eng_op   [64];
  logic [7:0] eng_data [64];
  logic       eng_nk   [64];

  i2c_txn_arbiter #(.TIMEOUT_CYCLES(16), .RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_rw_i(req_rw),
    .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_data_o(cmd_data), .cmd_nack_o(cmd_nack), .rsp_valid_i(rsp_valid),
    .rsp_ack_i(rsp_ack), .rsp_data_i(rsp_data)
  );

  i2c_txn_arbiter #(.TIMEOUT_CYCLES(16), .RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_rw_i(req_rw),
    .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .gnt_o(gnt_b), .done_o(done_b), .err_o(err_b), .rdata_o(rdata_b),
    .cmd_valid_o(cmd_valid_b), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op_b),
    .cmd_data_o(cmd_data_b), .cmd_nack_o(cmd_nack_b), .rsp_valid_i(rsp_valid),
    .rsp_ack_i(rsp_ack), .rsp_data_i(rsp_data)
  );

  always #5 clk = ~clk;

  // Byte-engine model: responds one cycle after each handshake.
  initial begin
    logic [1:0] s_op;
    logic [7:0] s_data;
    logic       s_nk;
    int         idx;
    rsp_valid = 1'b0;
    rsp_ack   = 1'b1;
    rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        s_op = cmd_op; s_data = cmd_data; s_nk = cmd_nack;
        @(posedge clk); #1;
        idx = eng_cnt;
        if (idx < 64) begin
          eng_op[idx] = s_op; eng_data[idx] = s_data; eng_nk[idx] = s_nk;
        end
        eng_cnt = eng_cnt + 1;
        if (idx != eng_hold && rst_n) begin
          rsp_valid = 1'b1;
          rsp_ack   = (idx != eng_nack);
          rsp_data  = eng_rdata;
          @(posedge clk); #1;
          rsp_valid = 1'b0;
          rsp_ack   = 1'b1;
        end
      end
    end
  end

  // Waits for a done pulse; cyc counts the request cycle as 1.
  task automatic wait_done(input int budget, output int cyc, output logic [1:0] d,
                           output logic [1:0] db, output logic [1:0] e, output bit to);
    cyc = 1; to = 1'b1; d = 2'b00; db = 2'b00; e = 2'b00;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 2'b00) begin
        d = done; db = done_b; e = err; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00;
    repeat (2) @(posedge clk); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got %b want 00", gnt); end
    total++; if (done !== 2'b00 || err !== 2'b00) begin bad++; $display("FAIL reset_done_err got %b/%b want 00/00", done, err); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    total++; if ({cmd_op, cmd_data, cmd_nack, rdata} !== 19'h0) begin bad++;
      $display("FAIL reset_cmd_fields got op=%0d data=%h nack=%b rdata=%h want 0", cmd_op, cmd_data, cmd_nack, rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int cyc, base; logic [1:0] d, db, e; bit to;
    logic [1:0] xop [5]; logic [7:0] xdat [5];
    xop  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    xdat = '{8'h00, 8'hCC, 8'h10, 8'hA5, 8'h00};
    base = eng_cnt;
    req_rw = 2'b00; req_dev = 14'h0066; req_reg = 16'h0010; req_wdata = 16'h00A5;
    req = 2'b01;
    wait_done(60, cyc, d, db, e, to);
    req = 2'b00;
    total++; if (to) begin bad++; $display("FAIL write_timeout got no done want done"); end
    total++; if (cyc != 12) begin bad++; $display("FAIL write_latency got %0d want 12", cyc); end
    total++; if (d !== 2'b01 || e !== 2'b00) begin bad++; $display("FAIL write_done_err got %b/%b want 01/00", d, e); end
    total++; if (eng_cnt - base != 5) begin bad++; $display("FAIL write_cmd_count got %0d want 5", eng_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (eng_op[base+i] !== xop[i] || (xop[i] == 2'd1 && eng_data[base+i] !== xdat[i])) begin
        bad++; $display("FAIL write_cmd%0d got op=%0d data=%h want op=%0d data=%h", i, eng_op[base+i], eng_data[base+i], xop[i], xdat[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    int cyc; logic [1:0] d, db, e; bit to;
    logic [1:0] xg [3];
    xg = '{2'b01, 2'b10, 2'b01};
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
    req_rw = 2'b00; req_dev = {7'h11, 7'h22}; req_reg = 16'h3344; req_wdata = 16'h5566;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_done(60, cyc, d, db, e, to);
      total++; if (to) begin bad++; $display("FAIL arb%0d_timeout got no done want done", k); end
      total++; if (d !== xg[k]) begin bad++; $display("FAIL arb%0d_rr got %b want %b", k, d, xg[k]); end
      total++; if (db !== 2'b01) begin bad++; $display("FAIL arb%0d_fixed got %b want 01", k, db); end
    end
    req = 2'b00;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_read();
    int cyc, base; logic [1:0] d, db, e; bit to;
    logic [1:0] xop [7]; logic [7:0] xdat [7];
    xop  = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    xdat = '{8'h00, 8'hCC, 8'h20, 8'h00, 8'hCD, 8'h00, 8'h00};
    base = eng_cnt; eng_rdata = 8'h5A;
    req_rw = 2'b10; req_dev = {7'h66, 7'h00}; req_reg = {8'h20, 8'h00}; req_wdata = 16'h0000;
    req = 2'b10;
    wait_done(80, cyc, d, db, e, to);
    req = 2'b00;
    total++; if (to) begin bad++; $display("FAIL read_timeout got no done want done"); end
    total++; if (d !== 2'b10 || e !== 2'b00) begin bad++; $display("FAIL read_done_err got %b/%b want 10/00", d, e); end
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL read_rdata got %h want 5a", rdata); end
    total++; if (eng_cnt - base != 7) begin bad++; $display("FAIL read_cmd_count got %0d want 7", eng_cnt - base); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (eng_op[base+i] !== xop[i] || (xop[i] == 2'd1 && eng_data[base+i] !== xdat[i])) begin
        bad++; $display("FAIL read_cmd%0d got op=%0d data=%h want op=%0d data=%h", i, eng_op[base+i], eng_data[base+i], xop[i], xdat[i]);
      end
    end
    total++; if (eng_nk[base+5] !== 1'b1) begin bad++; $display("FAIL read_nack got %b want 1", eng_nk[base+5]); end
    @(posedge clk); #1;
  endtask

  task automatic test_nack();
    int cyc, base; logic [1:0] d, db, e; bit to;
    base = eng_cnt; eng_nack = base + 1;
    req_rw = 2'b00; req_dev = 14'h0066; req_reg = 16'h0010; req_wdata = 16'h0033;
    req = 2'b01;
    wait_done(60, cyc, d, db, e, to);
    req = 2'b00; eng_nack = -1;
    total++; if (to) begin bad++; $display("FAIL nack_timeout got no done want done"); end
    total++; if (d !== 2'b01 || e !== 2'b01) begin bad++; $display("FAIL nack_done_err got %b/%b want 01/01", d, e); end
    total++; if (eng_cnt - base != 3) begin bad++; $display("FAIL nack_cmd_count got %0d want 3", eng_cnt - base); end
    total++; if (eng_op[base+2] !== 2'd3) begin bad++; $display("FAIL nack_next_cmd got op=%0d want 3", eng_op[base+2]); end
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL nack_rdata_hold got %h want 5a", rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cyc, base, k; logic [1:0] d, db, e; bit to, seen;
    base = eng_cnt; eng_hold = base + 2;
    req_rw = 2'b00; req_dev = 14'h0066; req_reg = 16'h0010; req_wdata = 16'h0077;
    req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #2;
      if (eng_cnt == base + 3) seen = 1'b1;
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      k++;
      if (cmd_valid && cmd_op == 2'd3) break;
    end
    total++; if (!seen || k != 16) begin bad++; $display("FAIL tmo_stop_delay got %0d (reg seen %b) want 16", k, seen); end
    wait_done(60, cyc, d, db, e, to);
    req = 2'b00; eng_hold = -1;
    total++; if (to) begin bad++; $display("FAIL tmo_timeout got no done want done"); end
    total++; if (d !== 2'b01 || e !== 2'b01) begin bad++; $display("FAIL tmo_done_err got %b/%b want 01/01", d, e); end
    total++; if (eng_cnt - base != 4 || eng_op[base+3] !== 2'd3) begin bad++;
      $display("FAIL tmo_cmds got count=%0d last_op=%0d want 4/3", eng_cnt - base, eng_op[base+3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    int cyc, base; logic [1:0] d, db, e; bit to, seen;
    base = eng_cnt; eng_hold = base + 5; eng_rdata = 8'h77;
    req_rw = 2'b10; req_dev = {7'h66, 7'h00}; req_reg = {8'h20, 8'h00};
    req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #2;
      if (eng_cnt == base + 6) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_reach_rdata got count=%0d want 6", eng_cnt - base); end
    @(posedge clk); #3;
    rst_n = 1'b0; req = 2'b00;
    #1;
    total++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin bad++;
      $display("FAIL rst_mid_gnt_done got %b/%b/%b want 00/00/00", gnt, done, err); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_mid_rdata got %h want 00", rdata); end
    total++; if ({cmd_valid, cmd_op, cmd_data, cmd_nack} !== 12'h0) begin bad++;
      $display("FAIL rst_mid_cmd got v=%b op=%0d data=%h nack=%b want 0", cmd_valid, cmd_op, cmd_data, cmd_nack); end
    eng_hold = -1;
    repeat (2) @(posedge clk); #1;
    total++; if (eng_cnt - base != 6) begin bad++; $display("FAIL rst_mid_no_stop got %0d want 6", eng_cnt - base); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = eng_cnt;
    req_rw = 2'b00; req_dev = 14'h0012; req_reg = 16'h0034; req_wdata = 16'h0056;
    req = 2'b01;
    wait_done(60, cyc, d, db, e, to);
    req = 2'b00;
    total++; if (to || cyc != 12) begin bad++; $display("FAIL rst_mid_new_latency got %0d (to=%b) want 12", cyc, to); end
    total++; if (eng_op[base] !== 2'd0 || eng_data[base+1] !== 8'h24) begin bad++;
      $display("FAIL rst_mid_new_cmds got op0=%0d dev=%h want 0/24", eng_op[base], eng_data[base+1]); end
    total++; if (d !== 2'b01 || e !== 2'b00) begin bad++; $display("FAIL rst_mid_new_done got %b/%b want 01/00", d, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; req_rw = 2'b00; req_dev = '0; req_reg = '0;
    req_wdata = '0; cmd_ready = 1'b1;
    test_reset();
    test_write();
    test_arbitration();
    test_read();
    test_nack();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
